fmul_72bit_arbiter: RTL and testbench

Shares one fmul_72bit pipeline between two independent requesters. Each cycle, round-robin arbitration picks one requester and issues its operands to the multiplier. An in-order tag FIFO records which port owns each in-flight operation. Each result is steered back to its owner with per-port backpressure. The block sits between two issue units (e.g. vector lanes) and a single fmul_72bit instance.

---
 rtl/fmul_72bit_arbiter.sv | 171 +++++++++++++++++
 tb/tb_fmul_72bit_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_72bit_arbiter.sv
// fmul_72bit_arbiter: shares one fmul_72bit pipeline between two requesters.
// Round-robin issue, in-order tag FIFO of owner ids, result steering with
// per-port backpressure. Optional grant/stall statistics: FMUL_ARB_STATS_EN.
module fmul_72bit_arbiter #(
  parameter int unsigned TAG_DEPTH = 8,
  parameter int unsigned TAG_AW    = 3
) (
  input  logic              iCLOCK,
  input  logic              iRESET_SYNC,
  input  logic              iREQ0_REQ,
  output logic              oREQ0_BUSY,
  input  logic [71:0]       iREQ0_A,
  input  logic [71:0]       iREQ0_B,
  input  logic              iREQ1_REQ,
  output logic              oREQ1_BUSY,
  input  logic [71:0]       iREQ1_A,
  input  logic [71:0]       iREQ1_B,
  output logic              oRES0_VALID,
  input  logic              iRES0_BUSY,
  output logic              oRES1_VALID,
  input  logic              iRES1_BUSY,
  output logic [71:0]       oRES_DATA,
  output logic              oFMUL_REQ,
  input  logic              iFMUL_BUSY,
  output logic [71:0]       oFMUL_A,
  output logic [71:0]       oFMUL_B,
  input  logic              iFMUL_VALID,
  output logic              oFMUL_BUSY,
  input  logic [71:0]       iFMUL_DATA,
`ifdef FMUL_ARB_STATS_EN
  output logic [31:0]       oSTAT_GRANT0,
  output logic [31:0]       oSTAT_GRANT1,
  output logic [31:0]       oSTAT_STALL,
`endif
  output logic [TAG_AW:0]   oOUTSTANDING,
  output logic              oERR_UNDERFLOW
);

  localparam int unsigned CW = TAG_AW + 1;

  // Round-robin pointer names the preferred port when both request.
  typedef enum logic {
    RR_P0 = 1'b0,
    RR_P1 = 1'b1
  } rr_e;

  rr_e               rr_q;
  rr_e               rr_d;

  logic              tag_mem [TAG_DEPTH];
  logic [TAG_AW-1:0] wr_ptr;
  logic [TAG_AW-1:0] rd_ptr;
  logic [CW-1:0]     count_q;
  logic              err_q;

  logic              any_req;
  logic              can_issue;
  logic              winner;
  logic              issue;
  logic              empty;
  logic              head;
  logic              head_busy;
  logic              pop;
  logic              underflow;

  // Issue path: arbitration and operand steering, zero added latency.
  always_comb begin
    any_req   = iREQ0_REQ || iREQ1_REQ;
    can_issue = !iFMUL_BUSY && (count_q < CW'(TAG_DEPTH));
    winner    = (iREQ0_REQ && iREQ1_REQ) ? (rr_q == RR_P1) : iREQ1_REQ;
    issue     = !iRESET_SYNC && can_issue && any_req;
    oFMUL_REQ = issue;
    oFMUL_A   = winner ? iREQ1_A : iREQ0_A;
    oFMUL_B   = winner ? iREQ1_B : iREQ0_B;
    oREQ0_BUSY = !(issue && !winner);
    oREQ1_BUSY = !(issue && winner);
  end

  // Next rr pointer: after any issue, prefer the other port.
  always_comb begin
    rr_d = rr_q;
    if (issue) begin
      rr_d = winner ? RR_P0 : RR_P1;
    end
  end

  // Return path: steer the multiplier result to the head tag's owner.
  always_comb begin
    empty       = (count_q == '0);
    head        = tag_mem[rd_ptr];
    head_busy   = head ? iRES1_BUSY : iRES0_BUSY;
    oRES_DATA   = iFMUL_DATA;
    oRES0_VALID = !iRESET_SYNC && iFMUL_VALID && !empty && !head;
    oRES1_VALID = !iRESET_SYNC && iFMUL_VALID && !empty && head;
    oFMUL_BUSY  = iRESET_SYNC ? 1'b1 : (empty ? 1'b0 : head_busy);
    pop         = !iRESET_SYNC && iFMUL_VALID && !empty && !head_busy;
    underflow   = !iRESET_SYNC && iFMUL_VALID && empty;
  end

  // Arbitration pointer register.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      rr_q <= RR_P0;
    end else begin
      rr_q <= rr_d;
    end
  end

  // Tag FIFO: owner id pushed on issue, popped on result delivery.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(TAG_DEPTH); i++) begin
        tag_mem[i] <= 1'b0;
      end
    end else begin
      if (issue) begin
        tag_mem[wr_ptr] <= winner;
        wr_ptr          <= wr_ptr + TAG_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + TAG_AW'(1);
      end
      count_q <= count_q + CW'(issue) - CW'(pop);
    end
  end

  // Sticky underflow flag: a result arrived with no tag to own it.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      err_q <= 1'b0;
    end else if (underflow) begin
      err_q <= 1'b1;
    end
  end

  assign oOUTSTANDING   = count_q;
  assign oERR_UNDERFLOW = err_q;

`ifdef FMUL_ARB_STATS_EN
  logic [31:0] grant0_q;
  logic [31:0] grant1_q;
  logic [31:0] stall_q;

  // Saturating grant and stall counters.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      grant0_q <= '0;
      grant1_q <= '0;
      stall_q  <= '0;
    end else begin
      if (issue && !winner && (grant0_q != '1)) begin
        grant0_q <= grant0_q + 32'd1;
      end
      if (issue && winner && (grant1_q != '1)) begin
        grant1_q <= grant1_q + 32'd1;
      end
      if (any_req && !can_issue && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign oSTAT_GRANT0 = grant0_q;
  assign oSTAT_GRANT1 = grant1_q;
  assign oSTAT_STALL  = stall_q;
`endif

endmodule

// File: tb/tb_fmul_72bit_arbiter.sv
// Directed self-checking bench for fmul_72bit_arbiter; the bench plays the
// role of the multiplier by driving iFMUL_VALID/iFMUL_DATA directly.
module tb_fmul_72bit_arbiter;

  localparam logic [71:0] ONE_72 = 72'h3F_FF80_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, res0_busy, res1_busy, fmul_busy_in, fmul_valid;
  logic [71:0] a0, b0, a1, b1, fmul_data;
  logic        busy0, busy1, res0_valid, res1_valid, fmul_req, fmul_busy_out;
  logic [71:0] res_data, fmul_a, fmul_b;
  logic [3:0]  outstanding;
  logic        err;
`ifdef FMUL_ARB_STATS_EN
  logic [31:0] st_g0, st_g1, st_st;
`endif

  int checks = 0;
  int errors = 0;
  int pushed;
  int popped;

  always #5 clk = ~clk;

  fmul_72bit_arbiter #(.TAG_DEPTH(8), .TAG_AW(3)) dut (
    .iCLOCK(clk), .iRESET_SYNC(rst),
    .iREQ0_REQ(req0), .oREQ0_BUSY(busy0), .iREQ0_A(a0), .iREQ0_B(b0),
    .iREQ1_REQ(req1), .oREQ1_BUSY(busy1), .iREQ1_A(a1), .iREQ1_B(b1),
    .oRES0_VALID(res0_valid), .iRES0_BUSY(res0_busy),
    .oRES1_VALID(res1_valid), .iRES1_BUSY(res1_busy),
    .oRES_DATA(res_data),
    .oFMUL_REQ(fmul_req), .iFMUL_BUSY(fmul_busy_in),
    .oFMUL_A(fmul_a), .oFMUL_B(fmul_b),
    .iFMUL_VALID(fmul_valid), .oFMUL_BUSY(fmul_busy_out), .iFMUL_DATA(fmul_data),
`ifdef FMUL_ARB_STATS_EN
    .oSTAT_GRANT0(st_g0), .oSTAT_GRANT1(st_g1), .oSTAT_STALL(st_st),
`endif
    .oOUTSTANDING(outstanding), .oERR_UNDERFLOW(err)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; res0_busy = 1'b0; res1_busy = 1'b0;
    fmul_busy_in = 1'b0; fmul_valid = 1'b1; fmul_data = '0;
    a0 = 72'h11; b0 = 72'h12; a1 = 72'h21; b1 = 72'h22;
    @(posedge clk); #1;

    // Outputs forced while reset is asserted
    chk("rst_busy0", busy0, 1);
    chk("rst_busy1", busy1, 1);
    chk("rst_fmul_req", fmul_req, 0);
    chk("rst_res0_valid", res0_valid, 0);
    chk("rst_res1_valid", res1_valid, 0);
    chk("rst_fmul_busy", fmul_busy_out, 1);
    fmul_valid = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err, 0);

    // Both ports request; results return 4 cycles after issue
    pushed = 0; popped = 0;
    for (int k = 0; k < 10; k++) begin
      req0 = (k < 6); req1 = (k < 6);
      a0 = 72'h100 + 72'(k); b0 = 72'h300 + 72'(k);
      a1 = 72'h200 + 72'(k); b1 = 72'h400 + 72'(k);
      fmul_valid = (k >= 4);
      fmul_data  = 72'h500 + 72'(k - 4);
      #1;
      chk("rr_outstanding", outstanding, 72'(pushed - popped));
      if (k < 6) begin
        chk("rr_fmul_req", fmul_req, 1);
        chk("rr_busy0", busy0, 72'(k % 2 == 1));
        chk("rr_busy1", busy1, 72'(k % 2 == 0));
        chk("rr_fmul_a", fmul_a, (k % 2 == 1) ? a1 : a0);
        chk("rr_fmul_b", fmul_b, (k % 2 == 1) ? b1 : b0);
        pushed++;
      end else begin
        chk("rr_idle_req", fmul_req, 0);
      end
      if (k >= 4) begin
        chk("rr_res0_valid", res0_valid, 72'(k % 2 == 0));
        chk("rr_res1_valid", res1_valid, 72'(k % 2 == 1));
        chk("rr_res_data", res_data, 72'h500 + 72'(k - 4));
        chk("rr_fmul_busy", fmul_busy_out, 0);
        popped++;
      end
      tick();
    end
    fmul_valid = 1'b0; req0 = 1'b0; req1 = 1'b0;
    #1;
    chk("rr_drained", outstanding, 0);

    // Port 1 alone issues three unit-value operations
    a1 = ONE_72; b1 = ONE_72; req1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("p1_busy1", busy1, 0);
      chk("p1_busy0", busy0, 1);
      chk("p1_fmul_a", fmul_a, ONE_72);
      tick();
    end
    req1 = 1'b0; fmul_valid = 1'b1; fmul_data = ONE_72;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("p1_res1_valid", res1_valid, 1);
      chk("p1_res0_valid", res0_valid, 0);
      chk("p1_res_data", res_data, ONE_72);
      tick();
    end
    fmul_valid = 1'b0;

    // Fill the tag FIFO from port 0 with no results returning
    req0 = 1'b1; a0 = 72'h600; b0 = 72'h601;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("full_outstanding", outstanding, 72'((k < 8) ? k : 8));
      chk("full_busy0", busy0, 72'(k >= 8));
      tick();
    end
    // Pop while full: issue still blocked this cycle
    fmul_valid = 1'b1; fmul_data = 72'h77;
    #1;
    chk("full_pop_busy0", busy0, 1);
    chk("full_pop_res0", res0_valid, 1);
    chk("full_pop_fmul_busy", fmul_busy_out, 0);
    tick();
    fmul_valid = 1'b0;
    #1;
    chk("full_after_pop_cnt", outstanding, 7);
    chk("full_after_pop_busy0", busy0, 0);
    tick();
    #1;
    chk("full_refill_cnt", outstanding, 8);
    chk("full_refill_busy0", busy0, 1);
    req0 = 1'b0; fmul_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("full_drain_res0", res0_valid, 1);
      chk("full_drain_res1", res1_valid, 0);
      tick();
    end
    fmul_valid = 1'b0;
    #1;
    chk("full_drained", outstanding, 0);

    // Head-of-line blocking on port 0 result backpressure
    req0 = 1'b1;
    #1;
    chk("hol_issue0", busy0, 0);
    tick();
    req0 = 1'b0; req1 = 1'b1;
    #1;
    chk("hol_issue1", busy1, 0);
    tick();
    req1 = 1'b0; fmul_valid = 1'b1; fmul_data = 72'hAA; res0_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("hol_fmul_busy", fmul_busy_out, 1);
      chk("hol_res0_valid", res0_valid, 1);
      chk("hol_res1_valid", res1_valid, 0);
      chk("hol_outstanding", outstanding, 2);
      tick();
    end
    res0_busy = 1'b0;
    #1;
    chk("hol_rel_res0", res0_valid, 1);
    chk("hol_rel_fmul_busy", fmul_busy_out, 0);
    chk("hol_rel_data", res_data, 72'hAA);
    tick();
    fmul_data = 72'hBB;
    #1;
    chk("hol_p1_res1", res1_valid, 1);
    chk("hol_p1_res0", res0_valid, 0);
    chk("hol_p1_data", res_data, 72'hBB);
    tick();
    fmul_valid = 1'b0;
    #1;
    chk("hol_drained", outstanding, 0);

    // Result with no tag: dropped, sticky error
    fmul_valid = 1'b1; fmul_data = 72'hCC;
    #1;
    chk("uf_fmul_busy", fmul_busy_out, 0);
    chk("uf_res0", res0_valid, 0);
    chk("uf_res1", res1_valid, 0);
    chk("uf_err_same", err, 0);
    tick();
    fmul_valid = 1'b0;
    #1;
    chk("uf_err_set", err, 1);
    tick();
    tick();
    chk("uf_err_held", err, 1);

    // Reset with three ops in flight (rr points at port 1 beforehand)
    req0 = 1'b1;
    tick(); tick(); tick();
    req0 = 1'b0;
    #1;
    chk("mid_outstanding", outstanding, 3);
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; fmul_valid = 1'b1;
    #1;
    chk("mid_rst_res0", res0_valid, 0);
    chk("mid_rst_fmul_busy", fmul_busy_out, 1);
    chk("mid_rst_fmul_req", fmul_req, 0);
    chk("mid_rst_busy0", busy0, 1);
    tick();
    rst = 1'b0; fmul_valid = 1'b0; a0 = 72'h700; a1 = 72'h701;
    #1;
    chk("post_rst_outstanding", outstanding, 0);
    chk("post_rst_err", err, 0);
    chk("post_rst_busy0", busy0, 0);
    chk("post_rst_busy1", busy1, 1);
    chk("post_rst_fmul_a", fmul_a, 72'h700);
    tick();
    chk("post_rst_alt_busy1", busy1, 0);
    chk("post_rst_alt_busy0", busy0, 1);
    req0 = 1'b0; req1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
